grid_nav_ctrl: RTL

GRID_NAV_CTRL -- requirements
Module: grid_nav_ctrl

---
 rtl/grid_nav_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/grid_nav_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grid_nav_ctrl
// Description : Cursor navigation over a 4-row x 5-column grid with a lock
//               toggle, plus a four-slot time-multiplexed display scan that
//               drives a row/column/letter decoder and active-low digit
//               enables.
// Ports       : clk        - system clock, rising-edge active
//               rst        - synchronous active-high reset
//               btn_up/down/left/right - debounced cursor buttons (levels)
//               btn_lock   - debounced lock toggle button (level)
//               row, col   - decoder row/column inputs (3 bits each)
//               alpha      - 1 = letter mode, 0 = digit mode
//               r_c        - in digit mode: 1 = row digit, 0 = column digit
//               an         - active-low digit enables, bit n = digit n
//               locked     - current lock state
// Revision    : 1.0 - initial release
// ============================================================================
module grid_nav_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_lock,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       alpha,
    output logic       r_c,
    output logic [3:0] an,
    output logic       locked
);

    localparam int unsigned c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

    // Display slot state encoding
    localparam logic [1:0] c_SLOT_COL  = 2'd0;
    localparam logic [1:0] c_SLOT_ROW  = 2'd1;
    localparam logic [1:0] c_SLOT_CHAR = 2'd2;
    localparam logic [1:0] c_SLOT_LOCK = 2'd3;

    // Button history bit positions
    localparam int c_B_UP    = 4;
    localparam int c_B_DOWN  = 3;
    localparam int c_B_LEFT  = 2;
    localparam int c_B_RIGHT = 1;
    localparam int c_B_LOCK  = 0;

    logic [4:0]         w_btn;
    logic [4:0]         r_hist;
    logic [4:0]         w_press;
    logic [2:0]         r_cur_row;
    logic [2:0]         r_cur_col;
    logic               r_locked;
    logic [c_CNT_W-1:0] r_scan_cnt;
    logic               w_scan_wrap;
    logic [1:0]         r_slot;
    logic [1:0]         w_slot_next;
    logic [3:0]         w_an;
    logic [2:0]         w_row;
    logic [2:0]         w_col;
    logic               w_alpha;
    logic               w_r_c;
    logic [3:0]         r_an;
    logic [2:0]         r_row;
    logic [2:0]         r_col;
    logic               r_alpha;
    logic               r_r_c;

    assign w_btn   = {btn_up, btn_down, btn_left, btn_right, btn_lock};
    // A press is the first cycle a button reads high; holding does nothing more.
    assign w_press = w_btn & ~r_hist;

    // ------------------------------------------------------------------
    // Buttons, cursor and lock
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // History preset high so a button held through reset is not a press.
            r_hist    <= 5'b11111;
            r_cur_row <= 3'd1;
            r_cur_col <= 3'd1;
            r_locked  <= 1'b0;
        end else begin
            r_hist <= w_btn;
            if (w_press[c_B_LOCK]) begin
                r_locked <= ~r_locked;
            end
            // Cursor presses see the lock value from before any toggle this cycle.
            // Only the highest-priority press acts; the rest are dropped.
            if (!r_locked) begin
                if (w_press[c_B_UP]) begin
                    r_cur_row <= (r_cur_row == 3'd1) ? 3'd4 : r_cur_row - 3'd1;
                end else if (w_press[c_B_DOWN]) begin
                    r_cur_row <= (r_cur_row == 3'd4) ? 3'd1 : r_cur_row + 3'd1;
                end else if (w_press[c_B_LEFT]) begin
                    r_cur_col <= (r_cur_col == 3'd1) ? 3'd5 : r_cur_col - 3'd1;
                end else if (w_press[c_B_RIGHT]) begin
                    r_cur_col <= (r_cur_col == 3'd5) ? 3'd1 : r_cur_col + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan counter (independent of cursor activity)
    // ------------------------------------------------------------------
    assign w_scan_wrap = (r_scan_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slot state machine: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= c_SLOT_COL;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    always_comb begin
        w_slot_next = r_slot;
        if (w_scan_wrap) begin
            w_slot_next = r_slot + 2'd1;
        end
    end

    always_comb begin
        w_an    = 4'b1111;
        w_row   = r_cur_row;
        w_col   = r_cur_col;
        w_alpha = 1'b0;
        w_r_c   = 1'b0;
        case (r_slot)
            c_SLOT_COL: begin
                w_an = 4'b1110;
            end
            c_SLOT_ROW: begin
                w_an  = 4'b1101;
                w_r_c = 1'b1;
            end
            c_SLOT_CHAR: begin
                w_an    = 4'b1011;
                w_alpha = 1'b1;
            end
            default: begin
                // Row/col of zero makes the decoder show a dash.
                w_an  = r_locked ? 4'b0111 : 4'b1111;
                w_row = 3'd0;
                w_col = 3'd0;
            end
        endcase
    end

    // Registered decoder and digit-enable outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an    <= 4'b1110;
            r_row   <= 3'd1;
            r_col   <= 3'd1;
            r_alpha <= 1'b0;
            r_r_c   <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_row   <= w_row;
            r_col   <= w_col;
            r_alpha <= w_alpha;
            r_r_c   <= w_r_c;
        end
    end

    assign an     = r_an;
    assign row    = r_row;
    assign col    = r_col;
    assign alpha  = r_alpha;
    assign r_c    = r_r_c;
    assign locked = r_locked;

endmodule
`default_nettype wire
